// File: rtl/overlap_add_stream.sv
// overlap_add_stream: per-channel IMDCT overlap/add with saturating lane sums and a zeroing sweep on reset/clear
module overlap_add_stream #(
    parameter int WORD_WIDTH = 16,
    parameter int LANES = 4,
    parameter int HALF_LEN = 512,
    parameter int CHANNELS = 2,
    localparam int BPH = HALF_LEN / LANES,
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*WORD_WIDTH-1:0] in_data,
    input  logic [CH_W-1:0]             in_ch,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*WORD_WIDTH-1:0] out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_last
);
    localparam int DEPTH = CHANNELS * BPH;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int BW = BPH > 1 ? $clog2(BPH) : 1;
    localparam int DW = LANES * WORD_WIDTH;
    localparam logic signed [WORD_WIDTH:0] MAX_V = {2'b00, {(WORD_WIDTH-1){1'b1}}};
    localparam logic signed [WORD_WIDTH:0] MIN_V = {2'b11, {(WORD_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_CLEAR, S_ADD, S_STORE} state_t;

    state_t state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, rd_addr, mem_addr;
    logic [BW-1:0] beat_q, beat_d;
    logic [CH_W-1:0] cur_ch_q, cur_ch_d, in_ch_m, ch, out_ch_q, out_ch_d;
    logic out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DW-1:0] out_data_q, out_data_d, rd_data, sum, mem_wdata;
    logic [DW-1:0] mem [DEPTH];
    logic mem_we, accept, last_beat;
    logic signed [WORD_WIDTH:0] s;

    // out-of-range channel numbers fold onto channel 0
    if (CHANNELS == (1 << CH_W)) begin : g_pow2
        assign in_ch_m = in_ch;
    end else begin : g_map
        assign in_ch_m = 32'(in_ch) < CHANNELS ? in_ch : '0;
    end

    always_comb begin
        ch = (state_q == S_ADD && beat_q == '0) ? in_ch_m : cur_ch_q;
        rd_addr = AW'(32'(ch) * BPH + 32'(beat_q));
        rd_data = mem[rd_addr];
        in_ready = !clear && (state_q == S_STORE || (state_q == S_ADD && (!out_valid_q || out_ready)));
        accept = in_valid && in_ready;
        last_beat = beat_q == BW'(BPH - 1);
        s = '0;
        sum = '0;
        for (int k = 0; k < LANES; k++) begin
            s = (WORD_WIDTH+1)'($signed(in_data[k*WORD_WIDTH +: WORD_WIDTH]))
              + (WORD_WIDTH+1)'($signed(rd_data[k*WORD_WIDTH +: WORD_WIDTH]));
            sum[k*WORD_WIDTH +: WORD_WIDTH] = s > MAX_V ? MAX_V[WORD_WIDTH-1:0] :
                                              s < MIN_V ? MIN_V[WORD_WIDTH-1:0] : s[WORD_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        beat_d = beat_q;
        cur_ch_d = cur_ch_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d = out_data_q;
        out_ch_d = out_ch_q;
        out_last_d = out_last_q;
        mem_we = 1'b0;
        mem_addr = rd_addr;
        mem_wdata = in_data;
        if (clear) begin
            state_d = S_CLEAR;
            addr_d = '0;
            beat_d = '0;
            out_valid_d = 1'b0;
        end else if (state_q == S_CLEAR) begin
            mem_we = 1'b1;
            mem_addr = addr_q;
            mem_wdata = '0;
            addr_d = addr_q == AW'(DEPTH - 1) ? '0 : addr_q + AW'(1);
            state_d = addr_q == AW'(DEPTH - 1) ? S_ADD : S_CLEAR;
            beat_d = '0;
        end else if (accept) begin
            beat_d = last_beat ? '0 : beat_q + BW'(1);
            if (state_q == S_ADD) begin
                out_valid_d = 1'b1;
                out_data_d = sum;
                out_ch_d = ch;
                out_last_d = last_beat;
                cur_ch_d = ch;
                state_d = last_beat ? S_STORE : S_ADD;
            end else begin
                mem_we = 1'b1;
                state_d = last_beat ? S_ADD : S_STORE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_CLEAR;
            addr_q <= '0;
            beat_q <= '0;
            cur_ch_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_ch_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            beat_q <= beat_d;
            cur_ch_q <= cur_ch_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_ch_q <= out_ch_d;
            out_last_q <= out_last_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_ch = out_ch_q;
    assign out_last = out_last_q;
endmodule

// File: tb/tb_overlap_add_stream.sv
// tb_overlap_add_stream: windows driven through the stage and checked against a per-channel sample-array model
module tb_overlap_add_stream;
    localparam int W = 16, L = 4, H = 8, C = 2, BPH = H / L, DW = W * L;

    typedef struct packed {logic ch; logic last; logic [DW-1:0] d;} ob_t;
    typedef int win_t [2*H];

    logic clock = 0, reset = 1, clear = 0, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last;
    logic [0:0] in_ch = '0, out_ch;
    logic [DW-1:0] in_data = '0, out_data;

    ob_t got_q[$], exp_q[$];
    int ovl [C][H];
    int vectors = 0, errors = 0;
    bit rand_bp = 0;

    overlap_add_stream #(.WORD_WIDTH(W), .LANES(L), .HALF_LEN(H), .CHANNELS(C)) dut (
        .clock(clock), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ch(in_ch), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (!reset && out_valid && out_ready) got_q.push_back({out_ch, out_last, out_data});

    initial begin
        #500000;
        $display("FAIL watchdog: run still going, required to finish");
        $fatal(1);
    end

    function automatic int sat(int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic logic [DW-1:0] pack(win_t w, int b);
        logic [DW-1:0] p;
        for (int k = 0; k < L; k++) p[k*W +: W] = W'(w[b*L+k]);
        return p;
    endfunction

    function automatic ob_t got_at(int i);
        return i < got_q.size() ? got_q[i] : '0;
    endfunction

    task automatic mk(output win_t w, input int a, input int b);
        for (int i = 0; i < H; i++) begin
            w[i] = a;
            w[H+i] = b;
        end
    endtask

    task automatic rnd(output win_t w);
        for (int i = 0; i < 2*H; i++) w[i] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic zero_model();
        for (int c = 0; c < C; c++) for (int i = 0; i < H; i++) ovl[c][i] = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    // first half adds the channel's stored half; second half replaces it
    task automatic model_window(input int ch, input win_t w);
        ob_t e;
        for (int b = 0; b < BPH; b++) begin
            e.ch = 1'(ch);
            e.last = b == BPH - 1;
            for (int k = 0; k < L; k++) e.d[k*W +: W] = W'(sat(w[b*L+k] + ovl[ch][b*L+k]));
            exp_q.push_back(e);
        end
        for (int i = 0; i < H; i++) ovl[ch][i] = w[H+i];
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic ch);
        bit ok = 0;
        in_valid = 1;
        in_data = d;
        in_ch = ch;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clock);
            ok = in_ready;
            @(posedge clock);
            #1;
        end
        in_valid = 0;
        in_ch = 1'($urandom_range(0, 1));
        if (!ok) begin
            errors++;
            $display("FAIL send_beat timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic run_window(input int ch, input win_t w);
        model_window(ch, w);
        for (int b = 0; b < 2*BPH; b++) send_beat(pack(w, b), b == 0 ? 1'(ch) : 1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        rand_bp = 0;
        out_ready = 1;
        in_valid = 0;
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        win_t w;
        reset = 1;
        zero_model();
        @(negedge clock);
        vectors++;
        if ({in_ready, out_valid, out_data, out_ch, out_last} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h, want 0", {in_ready, out_valid, out_data, out_ch, out_last});
        end
        @(posedge clock);
        #1;
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 1'(i == 4)) begin
                errors++;
                $display("FAIL reset_sweep cycle %0d in_ready got %b, want %b", i, in_ready, i == 4);
            end
            @(posedge clock);
            #1;
        end
        mk(w, 100, 100);
        run_window(0, w);
        drain();
        vectors += 3;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL reset_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        if (got_at(0) !== {1'b0, 1'b0, {L{16'd100}}}) begin
            errors++;
            $display("FAIL reset_first got %h, want all 100 not last", got_at(0));
        end
        if (got_at(1) !== {1'b0, 1'b1, {L{16'd100}}}) begin
            errors++;
            $display("FAIL reset_second got %h, want all 100 last", got_at(1));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_overlap();
        win_t w;
        mk(w, 100, 50);
        run_window(0, w);
        rnd(w);
        for (int i = 0; i < H; i++) w[i] = 7;
        run_window(0, w);
        drain();
        vectors += 3;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overlap_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (got_at(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL overlap_beat%0d got %h, want %h", i, got_at(i), exp_q[i]);
            end
        end
        if (got_at(2).d !== {L{16'd57}} || got_at(3).d !== {L{16'd57}}) begin
            errors++;
            $display("FAIL overlap_57 got %h %h, want all 57", got_at(2).d, got_at(3).d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_channels();
        win_t w;
        mk(w, 5, 1000);
        run_window(0, w);
        mk(w, -9, -3);
        run_window(1, w);
        mk(w, 3, 20);
        run_window(1, w);
        mk(w, 1, 30);
        run_window(0, w);
        drain();
        vectors += 3;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL chan_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (got_at(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL chan_beat%0d got %h, want %h", i, got_at(i), exp_q[i]);
            end
        end
        if (got_at(4) !== {1'b1, 1'b0, {L{16'd0}}} || got_at(5) !== {1'b1, 1'b1, {L{16'd0}}}) begin
            errors++;
            $display("FAIL chan_ch1 got %h %h, want ch1 all 0", got_at(4), got_at(5));
        end
        if (got_at(6) !== {1'b0, 1'b0, {L{16'd1001}}} || got_at(7) !== {1'b0, 1'b1, {L{16'd1001}}}) begin
            errors++;
            $display("FAIL chan_ch0 got %h %h, want ch0 all 1001", got_at(6), got_at(7));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_saturation();
        win_t w;
        mk(w, 0, 30000);
        run_window(0, w);
        mk(w, 0, -30000);
        run_window(1, w);
        mk(w, 5000, 0);
        for (int i = 0; i < H; i++) w[H+i] = i % 2 == 0 ? 32767 : 0;
        run_window(0, w);
        mk(w, -5000, 0);
        run_window(1, w);
        mk(w, 1, 0);
        run_window(0, w);
        drain();
        vectors += 4;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sat_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (got_at(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL sat_beat%0d got %h, want %h", i, got_at(i), exp_q[i]);
            end
        end
        if (got_at(4).d !== {L{16'h7fff}}) begin
            errors++;
            $display("FAIL sat_pos got %h, want all 7fff", got_at(4).d);
        end
        if (got_at(6).d !== {L{16'h8000}}) begin
            errors++;
            $display("FAIL sat_neg got %h, want all 8000", got_at(6).d);
        end
        if (got_at(8).d !== {16'h0001, 16'h7fff, 16'h0001, 16'h7fff}) begin
            errors++;
            $display("FAIL sat_mixed got %h, want 00017fff00017fff", got_at(8).d);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        win_t w;
        rnd(w);
        model_window(1, w);
        out_ready = 0;
        send_beat(pack(w, 0), 1'b1);
        in_valid = 1;
        in_data = pack(w, 1);
        in_ch = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 0 || out_valid !== 1 || out_data !== exp_q[0].d) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got ready=%b valid=%b data=%h, want 0 1 %h",
                         i, in_ready, out_valid, out_data, exp_q[0].d);
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1;
        send_beat(pack(w, 1), 1'b0);
        out_ready = 0;
        send_beat(pack(w, 2), 1'b0);
        send_beat(pack(w, 3), 1'b0);
        vectors++;
        if (out_valid !== 1 || out_data !== exp_q[1].d) begin
            errors++;
            $display("FAIL bp_store got valid=%b data=%h, want 1 %h", out_valid, out_data, exp_q[1].d);
        end
        out_ready = 1;
        rnd(w);
        run_window(1, w);
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (got_at(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d got %h, want %h", i, got_at(i), exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clear();
        win_t w;
        rnd(w);
        out_ready = 0;
        send_beat(pack(w, 0), 1'b0);
        in_valid = 1;
        in_data = pack(w, 1);
        clear = 1;
        @(negedge clock);
        vectors++;
        if (in_ready !== 0) begin
            errors++;
            $display("FAIL clear_ready got %b, want 0", in_ready);
        end
        @(posedge clock);
        #1;
        clear = 0;
        in_valid = 0;
        vectors++;
        if (out_valid !== 0) begin
            errors++;
            $display("FAIL clear_valid got %b, want 0", out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 1'(i == 4)) begin
                errors++;
                $display("FAIL clear_sweep cycle %0d in_ready got %b, want %b", i, in_ready, i == 4);
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1;
        zero_model();
        rnd(w);
        run_window(1, w);
        drain();
        vectors += 2;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL clear_count got %0d, want 2", got_q.size());
        end
        if (got_at(0).d !== pack(w, 0) || got_at(1).d !== pack(w, 1)) begin
            errors++;
            $display("FAIL clear_passthru got %h %h, want %h %h", got_at(0).d, got_at(1).d, pack(w, 0), pack(w, 1));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        win_t w;
        rnd(w);
        out_ready = 0;
        send_beat(pack(w, 0), 1'b1);
        #3;
        reset = 1;
        #1;
        vectors++;
        if ({in_ready, out_valid, out_data, out_ch, out_last} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs got %h, want 0", {in_ready, out_valid, out_data, out_ch, out_last});
        end
        @(posedge clock);
        #1;
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (in_ready !== 1'(i == 4)) begin
                errors++;
                $display("FAIL rstmid_sweep cycle %0d in_ready got %b, want %b", i, in_ready, i == 4);
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1;
        zero_model();
        rnd(w);
        run_window(0, w);
        drain();
        vectors += 2;
        if (got_q.size() != 2) begin
            errors++;
            $display("FAIL rstmid_count got %0d, want 2", got_q.size());
        end
        if (got_at(0).d !== pack(w, 0) || got_at(1).d !== pack(w, 1)) begin
            errors++;
            $display("FAIL rstmid_passthru got %h %h, want %h %h", got_at(0).d, got_at(1).d, pack(w, 0), pack(w, 1));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        win_t w;
        rand_bp = 1;
        for (int n = 0; n < 24; n++) begin
            rnd(w);
            run_window(int'($urandom_range(0, C - 1)), w);
        end
        drain();
        vectors++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d, want %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            vectors++;
            if (got_at(i) !== exp_q[i]) begin
                errors++;
                $display("FAIL random_beat%0d got %h, want %h", i, got_at(i), exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_channels();
        test_saturation();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
